// File: rtl/serial_frame_loader.sv
// serial_frame_loader
// Serial-to-parallel frame loader. Accepts one bit per cycle under a
// valid/ready handshake, builds an N-bit frame MSB first, then freezes it
// and holds frame_valid until the consumer takes it. Bits offered while a
// completed frame is waiting are dropped and latch a sticky overrun flag.
// All outputs are registered or decoded from registered state only.

module serial_frame_loader #(
    parameter int unsigned N  = 127,
    parameter int unsigned CW = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          din,
    input  logic          din_valid,
    output logic          din_ready,
    output logic [N-1:0]  frame,
    output logic          frame_valid,
    input  logic          frame_ready,
    output logic [CW-1:0] bit_cnt,
    output logic          overrun
);

    // Two-state controller: FILL shifts bits in, HOLD presents the frame.
    localparam logic [0:0] FILL = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    // Count value of the last bit of a frame, and the count shown in HOLD.
    localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(N);

    logic [0:0] state;
    logic       accept;
    logic       last_bit;

    // Handshake outputs are pure decodes of the registered state.
    assign din_ready   = (state == FILL);
    assign frame_valid = (state == HOLD);

    assign accept   = din_valid & din_ready;
    assign last_bit = (bit_cnt == LAST_CNT);

    // State register: FILL -> HOLD on the Nth accept, HOLD -> FILL on handoff.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FILL;
        end else begin
            case (state)
                FILL: begin
                    if (accept && last_bit) begin
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (frame_ready) begin
                        state <= FILL;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

    // Frame shift register: shifts only on accept, so it is frozen in HOLD
    // and keeps stale contents after handoff until overwritten.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame <= '0;
        end else if (accept) begin
            frame <= {frame[N-2:0], din};
        end
    end

    // Bit counter: counts accepts in FILL, reads N in HOLD, clears on handoff.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt <= '0;
        end else begin
            case (state)
                FILL: begin
                    if (accept) begin
                        bit_cnt <= last_bit ? FULL_CNT : bit_cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (frame_ready) begin
                        bit_cnt <= '0;
                    end
                end
                default: bit_cnt <= '0;
            endcase
        end
    end

    // Sticky overrun: any bit offered in HOLD (handoff cycle included).
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun <= 1'b0;
        end else if ((state == HOLD) && din_valid) begin
            overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_serial_frame_loader.sv
// tb_serial_frame_loader
// Self-checking bench for serial_frame_loader. A reference model keeps the
// full history of accepted bits; the expected frame is the most recent N
// accepted bits since reset, MSB first, zero-padded when fewer exist.

module tb_serial_frame_loader;

    localparam int unsigned N  = 127;
    localparam int unsigned CW = 7;

    logic          clk;
    logic          rst;
    logic          din;
    logic          din_valid;
    logic          din_ready;
    logic [N-1:0]  frame;
    logic          frame_valid;
    logic          frame_ready;
    logic [CW-1:0] bit_cnt;
    logic          overrun;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    bit     hist[$];
    int     m_cnt  = 0;
    bit     m_hold = 0;
    bit     m_ovr  = 0;

    logic [N-1:0] all_ones;
    logic [N-1:0] all_zeros;

    serial_frame_loader #(.N(N), .CW(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .din_valid   (din_valid),
        .din_ready   (din_ready),
        .frame       (frame),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .bit_cnt     (bit_cnt),
        .overrun     (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected frame: last N accepted bits, newest at bit 0.
    function automatic logic [N-1:0] exp_frame();
        logic [N-1:0] r;
        r = '0;
        for (int i = 0; i < int'(N); i++) begin
            int idx;
            idx = hist.size() - 1 - i;
            if (idx >= 0) r[i] = hist[idx];
        end
        return r;
    endfunction

    // Advance one clock edge, applying the loader's rules to the model, then
    // settle 1 time unit so outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            hist.delete();
            m_cnt  = 0;
            m_hold = 0;
            m_ovr  = 0;
        end else if (m_hold) begin
            if (din_valid) m_ovr = 1;
            if (frame_ready) begin
                m_hold = 0;
                m_cnt  = 0;
            end
        end else if (din_valid) begin
            hist.push_back(din);
            m_cnt++;
            if (m_cnt == int'(N)) m_hold = 1;
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        din_valid = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic send_bit(input bit b);
        din = b;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (frame !== all_zeros) begin n_fail++; $display("FAIL reset_frame got=%h exp=%h", frame, all_zeros); end
        n_checks++; if (bit_cnt !== 7'd0) begin n_fail++; $display("FAIL reset_bit_cnt got=%0d exp=0", bit_cnt); end
        n_checks++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL reset_frame_valid got=%b exp=0", frame_valid); end
        n_checks++; if (din_ready !== 1'b1) begin n_fail++; $display("FAIL reset_din_ready got=%b exp=1", din_ready); end
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
    endtask

    task automatic test_all_ones();
        do_reset();
        frame_ready = 1'b0;
        for (int i = 0; i < int'(N); i++) begin
            send_bit(1'b1);
            if (i == int'(N) - 2) begin
                n_checks++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL ones_early_valid got=%b exp=0", frame_valid); end
                n_checks++; if (bit_cnt !== 7'(N - 1)) begin n_fail++; $display("FAIL ones_cnt_126 got=%0d exp=%0d", bit_cnt, N - 1); end
            end
        end
        n_checks++; if (frame_valid !== 1'b1) begin n_fail++; $display("FAIL ones_valid got=%b exp=1", frame_valid); end
        n_checks++; if (frame !== all_ones) begin n_fail++; $display("FAIL ones_frame got=%h exp=%h", frame, all_ones); end
        n_checks++; if ($countones(frame) != 127) begin n_fail++; $display("FAIL ones_count got=%0d exp=127", $countones(frame)); end
        n_checks++; if (bit_cnt !== 7'd127) begin n_fail++; $display("FAIL ones_bit_cnt got=%0d exp=127", bit_cnt); end
        n_checks++; if (din_ready !== 1'b0) begin n_fail++; $display("FAIL ones_din_ready got=%b exp=0", din_ready); end
    endtask

    task automatic test_alternating();
        do_reset();
        frame_ready = 1'b1;
        for (int i = 0; i < int'(N); i++) send_bit((i % 2) == 0);
        n_checks++; if (frame_valid !== 1'b1) begin n_fail++; $display("FAIL alt_valid got=%b exp=1", frame_valid); end
        n_checks++; if (frame[126] !== 1'b1) begin n_fail++; $display("FAIL alt_msb got=%b exp=1", frame[126]); end
        n_checks++; if (frame[0] !== 1'b1) begin n_fail++; $display("FAIL alt_lsb got=%b exp=1", frame[0]); end
        n_checks++; if ($countones(frame) != 64) begin n_fail++; $display("FAIL alt_count got=%0d exp=64", $countones(frame)); end
        n_checks++; if (frame !== exp_frame()) begin n_fail++; $display("FAIL alt_frame got=%h exp=%h", frame, exp_frame()); end
        tick();
        n_checks++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL alt_hold_len got=%b exp=0", frame_valid); end
        n_checks++; if (bit_cnt !== 7'd0) begin n_fail++; $display("FAIL alt_cnt_clear got=%0d exp=0", bit_cnt); end
        n_checks++; if (din_ready !== 1'b1) begin n_fail++; $display("FAIL alt_ready_back got=%b exp=1", din_ready); end
    endtask

    task automatic test_back_to_back();
        int frames;
        int cyc;
        int low_ready;
        do_reset();
        frame_ready = 1'b1;
        frames = 0;
        cyc = 0;
        low_ready = 0;
        while (frames < 3 && cyc < 3000) begin
            din_valid = din_ready ? 1'($urandom_range(0, 1)) : 1'b0;
            din = 1'($urandom_range(0, 1));
            tick();
            cyc++;
            if (!din_ready) low_ready++;
            n_checks++; if (int'(bit_cnt) != m_cnt) begin n_fail++; $display("FAIL b2b_bit_cnt cyc=%0d got=%0d exp=%0d", cyc, bit_cnt, m_cnt); end
            n_checks++; if (frame_valid !== m_hold) begin n_fail++; $display("FAIL b2b_valid cyc=%0d got=%b exp=%b", cyc, frame_valid, m_hold); end
            if (m_hold) begin
                n_checks++; if (frame !== exp_frame()) begin n_fail++; $display("FAIL b2b_frame%0d got=%h exp=%h", frames, frame, exp_frame()); end
                frames++;
            end
        end
        din_valid = 1'b0;
        tick();
        n_checks++; if (frames != 3) begin n_fail++; $display("FAIL b2b_timeout got=%0d frames exp=3", frames); end
        n_checks++; if (low_ready != 3) begin n_fail++; $display("FAIL b2b_ready_low_cycles got=%0d exp=3", low_ready); end
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL b2b_overrun got=%b exp=0", overrun); end
    endtask

    task automatic test_overrun();
        logic [N-1:0] held;
        do_reset();
        frame_ready = 1'b0;
        for (int i = 0; i < int'(N); i++) send_bit(1'($urandom_range(0, 1)));
        held = exp_frame();
        n_checks++; if (frame !== held) begin n_fail++; $display("FAIL ovr_frame_in got=%h exp=%h", frame, held); end
        for (int i = 0; i < 10; i++) begin
            send_bit(1'($urandom_range(0, 1)));
            n_checks++; if (frame !== held) begin n_fail++; $display("FAIL ovr_frame_hold i=%0d got=%h exp=%h", i, frame, held); end
            n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_flag i=%0d got=%b exp=1", i, overrun); end
        end
        frame_ready = 1'b1;
        send_bit(1'b1);
        frame_ready = 1'b0;
        n_checks++; if (bit_cnt !== 7'd0) begin n_fail++; $display("FAIL ovr_handoff_drop got=%0d exp=0", bit_cnt); end
        for (int i = 0; i < int'(N); i++) send_bit(1'($urandom_range(0, 1)));
        n_checks++; if (frame !== exp_frame()) begin n_fail++; $display("FAIL ovr_next_frame got=%h exp=%h", frame, exp_frame()); end
        n_checks++; if (overrun !== m_ovr) begin n_fail++; $display("FAIL ovr_sticky got=%b exp=%b", overrun, m_ovr); end
    endtask

    task automatic test_reset_mid();
        // Leave HOLD from the previous test without clearing overrun.
        frame_ready = 1'b1;
        tick();
        frame_ready = 1'b0;
        for (int i = 0; i < 60; i++) send_bit(1'($urandom_range(0, 1)));
        n_checks++; if (int'(bit_cnt) != 60) begin n_fail++; $display("FAIL mid_cnt60 got=%0d exp=60", bit_cnt); end
        do_reset();
        n_checks++; if (bit_cnt !== 7'd0) begin n_fail++; $display("FAIL mid_cnt_reset got=%0d exp=0", bit_cnt); end
        for (int i = 0; i < int'(N); i++) send_bit(1'b0);
        n_checks++; if (frame_valid !== 1'b1) begin n_fail++; $display("FAIL mid_valid got=%b exp=1", frame_valid); end
        n_checks++; if (frame !== all_zeros) begin n_fail++; $display("FAIL mid_frame got=%h exp=%h", frame, all_zeros); end
        n_checks++; if ($countones(frame) != 0) begin n_fail++; $display("FAIL mid_count got=%0d exp=0", $countones(frame)); end
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL mid_overrun got=%b exp=0", overrun); end
    endtask

    task automatic test_reset_hold();
        do_reset();
        frame_ready = 1'b0;
        for (int i = 0; i < int'(N); i++) send_bit(1'b1);
        rst = 1'b1;
        frame_ready = 1'b1;
        din = 1'b1;
        din_valid = 1'b1;
        tick();
        rst = 1'b0;
        din_valid = 1'b0;
        frame_ready = 1'b0;
        n_checks++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL rh_valid got=%b exp=0", frame_valid); end
        n_checks++; if (frame !== all_zeros) begin n_fail++; $display("FAIL rh_frame got=%h exp=%h", frame, all_zeros); end
        n_checks++; if (bit_cnt !== 7'd0) begin n_fail++; $display("FAIL rh_bit_cnt got=%0d exp=0", bit_cnt); end
        n_checks++; if (din_ready !== 1'b1) begin n_fail++; $display("FAIL rh_din_ready got=%b exp=1", din_ready); end
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL rh_overrun got=%b exp=0", overrun); end
    endtask

    initial begin
        all_ones    = '1;
        all_zeros   = '0;
        rst         = 1'b1;
        din         = 1'b0;
        din_valid   = 1'b0;
        frame_ready = 1'b0;
        #2;
        test_reset();
        test_all_ones();
        test_alternating();
        test_back_to_back();
        test_overrun();
        test_reset_mid();
        test_reset_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=completion");
        $fatal(1, "watchdog");
    end

endmodule
